// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: dibit type, FSM states and the constellation table
// used by both the transmit mapper and the receive demapper.
package qpsk_pkg;

  typedef logic [1:0] dibit_t;

  typedef enum logic {COLLECT, HOLD} state_t;

  // Constellation codes named by the sign of (real, imag): P = +, N = -
  localparam dibit_t QPSK_PP = 2'b00;
  localparam dibit_t QPSK_NP = 2'b01;
  localparam dibit_t QPSK_NN = 2'b10;
  localparam dibit_t QPSK_PN = 2'b11;

  function automatic dibit_t qpsk_demap(input logic r, input logic i);
    dibit_t d;
    case ({r, i})
      2'b11:   d = QPSK_PP;
      2'b01:   d = QPSK_NP;
      2'b00:   d = QPSK_NN;
      default: d = QPSK_PN;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/qpsk_demap_deframe.sv
// Demaps hard-decision QPSK symbols to dibits, packs N_SYM of them MSB-first
// into a word, strips the trailing pad bit and hands the word to a valid/ready sink.
module qpsk_demap_deframe
  import qpsk_pkg::*;
#(
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  input  logic              real_part,
  input  logic              img_part,
  output logic              sym_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pad_error,
  output logic              complete
);

  localparam int N_SYM = (DATA_W + 1) / 2;
  localparam int BUF_W = 2 * N_SYM;
  localparam int CNT_W = $clog2(N_SYM + 1);

  state_t             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [BUF_W-1:0]   buf_q;
  logic [BUF_W-1:0]   buf_d;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               pad_error_q;
  logic               complete_q;
  logic               sym_ready_q;
  logic               accept_d;
  logic               last_d;

  // Symbol k lands at the top-down slot so the first symbol carries the word MSBs
  always_comb begin
    buf_d    = buf_q;
    buf_d[BUF_W - 1 - 2 * int'(count_q) -: 2] = qpsk_demap(real_part, img_part);
    accept_d = (state_q == COLLECT) && sym_valid && sym_ready_q && !flush;
    last_d   = (count_q == CNT_W'(N_SYM - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pad_error_q <= 1'b0;
      complete_q  <= 1'b0;
      sym_ready_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          sym_ready_q <= 1'b1;
          if (flush) begin
            count_q <= '0;
            buf_q   <= '0;
          end else if (accept_d) begin
            if (last_d) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= buf_d[DATA_W:1];
              pad_error_q <= buf_d[0];
              sym_ready_q <= 1'b0;
              count_q     <= '0;
              buf_q       <= '0;
            end else begin
              buf_q   <= buf_d;
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // flush is deliberately ignored here so a finished word is never lost
          if (out_ready) begin
            out_valid_q <= 1'b0;
            pad_error_q <= 1'b0;
            complete_q  <= 1'b1;
            sym_ready_q <= 1'b1;
            state_q     <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign sym_ready = sym_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pad_error = pad_error_q;
  assign complete  = complete_q;

endmodule

// File: tb/tb_qpsk_demap_deframe.sv
// Randomized and directed bench for qpsk_demap_deframe, checked against a
// queue-based word model built from the constellation table and packing rules.
module tb_qpsk_demap_deframe;

  localparam int DATA_W = 21;
  localparam int N_SYM  = (DATA_W + 1) / 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              symValid;
  logic              realPart;
  logic              imgPart;
  logic              symReady;
  logic              flush;
  logic [DATA_W-1:0] outData;
  logic              outValid;
  logic              outReady;
  logic              padError;
  logic              complete;

  int checkCount = 0;
  int failCount  = 0;

  // Behavioural model state
  logic [1:0]        dibQ[$];
  bit                mHold;
  bit                mReady;
  bit                mValid;
  bit                mPad;
  bit                mComplete;
  bit                mAccepted;
  logic [DATA_W-1:0] mData;

  qpsk_demap_deframe #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sym_valid (symValid),
    .real_part (realPart),
    .img_part  (imgPart),
    .sym_ready (symReady),
    .flush     (flush),
    .out_data  (outData),
    .out_valid (outValid),
    .out_ready (outReady),
    .pad_error (padError),
    .complete  (complete)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checkCount, failCount);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Constellation: (+,+)->0, (-,+)->1, (-,-)->2, (+,-)->3
  function automatic logic [1:0] refMap(input bit r, input bit i);
    if (r && i)   return 2'd0;
    if (!r && i)  return 2'd1;
    if (!r && !i) return 2'd2;
    return 2'd3;
  endfunction

  task automatic modelStep(input bit v, input bit r, input bit i, input bit f,
                           input bit ordy, input bit rst);
    longint unsigned word;
    bit canTake;
    mAccepted = 0;
    mComplete = 0;
    if (rst) begin
      dibQ.delete();
      mHold  = 0;
      mReady = 0;
      mValid = 0;
      mPad   = 0;
      mData  = '0;
    end else if (mHold) begin
      if (ordy) begin
        mValid    = 0;
        mPad      = 0;
        mComplete = 1;
        mHold     = 0;
        mReady    = 1;
      end
    end else begin
      canTake = mReady;
      mReady  = 1;
      if (f) begin
        dibQ.delete();
      end else if (v && canTake) begin
        dibQ.push_back(refMap(r, i));
        mAccepted = 1;
        if (dibQ.size() == N_SYM) begin
          word = 0;
          for (int k = 0; k < N_SYM; k++)
            word += longint'(dibQ[k]) * (64'd1 << (2 * (N_SYM - 1 - k)));
          mData  = DATA_W'(word >> 1);
          mPad   = word[0];
          mValid = 1;
          mHold  = 1;
          mReady = 0;
          dibQ.delete();
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input bit r, input bit i, input bit f,
                               input bit ordy, input bit rst);
    symValid = v;
    realPart = r;
    imgPart  = i;
    flush    = f;
    outReady = ordy;
    reset    = rst;
    modelStep(v, r, i, f, ordy, rst);
    @(posedge clk);
    #1;
    checkOutput("sym_ready", 32'(symReady), 32'(mReady));
    checkOutput("out_valid", 32'(outValid), 32'(mValid));
    checkOutput("out_data",  32'(outData),  32'(mData));
    checkOutput("pad_error", 32'(padError), 32'(mPad));
    checkOutput("complete",  32'(complete), 32'(mComplete));
  endtask

  task automatic sendSymbol(input bit r, input bit i);
    int tries = 0;
    do begin
      applyStimulus(1, r, i, 0, 0, 0);
      tries++;
    end while (!mAccepted && tries < 20);
    checkOutput("accept_bound", 32'(mAccepted), 32'd1);
  endtask

  task automatic sendWord(input bit bodyR, input bit bodyI, input bit lastR, input bit lastI);
    for (int k = 0; k < N_SYM - 1; k++) sendSymbol(bodyR, bodyI);
    sendSymbol(lastR, lastI);
  endtask

  task automatic checkWord(input string tag, input logic [DATA_W-1:0] expData, input bit expPad);
    checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_data"},  32'(outData),  32'(expData));
    checkOutput({tag, "_pad"},   32'(padError), 32'(expPad));
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput({tag, "_complete"}, 32'(complete), 32'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] heldData;
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("reset_valid", 32'(outValid), 32'd0);
    checkOutput("reset_ready", 32'(symReady), 32'd0);

    $display("[TB] directed words");
    sendWord(0, 0, 0, 0);
    checkWord("t1", 21'h155555, 1'b0);
    sendWord(1, 1, 1, 1);
    checkWord("t2", 21'h000000, 1'b0);
    sendWord(1, 0, 0, 0);
    checkWord("t3", 21'h1FFFFF, 1'b0);
    sendWord(1, 1, 1, 0);
    checkWord("t4", 21'h000001, 1'b1);

    $display("[TB] backpressure");
    for (int k = 0; k < N_SYM; k++) sendSymbol(1'($urandom), 1'($urandom));
    heldData = mData;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1'($urandom), 1'($urandom), 0, 0, 0);
      checkOutput("t5_stable", 32'(outData), 32'(heldData));
      checkOutput("t5_ready",  32'(symReady), 32'd0);
    end
    applyStimulus(1, 0, 1, 0, 1, 0);
    checkOutput("t5_complete", 32'(complete), 32'd1);
    sendWord(0, 1, 0, 1);
    checkWord("t5_next", 21'h0AAAAA, 1'b1);

    $display("[TB] flush and reset in hold");
    for (int k = 0; k < 4; k++) sendSymbol(1, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    sendWord(0, 0, 0, 0);
    checkWord("t6", 21'h155555, 1'b0);
    sendWord(1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 1, 1);
    checkOutput("t6_rst_valid",    32'(outValid), 32'd0);
    checkOutput("t6_rst_complete", 32'(complete), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 4000; n++) begin
      applyStimulus($urandom_range(99) < 70, 1'($urandom), 1'($urandom),
                    $urandom_range(99) < 3, $urandom_range(99) < 50,
                    $urandom_range(999) < 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
